// File: rtl/accum.sv
// Saturating unsigned fixed-point accumulator. It sums a programmed number of
// Q(wholeWidth.fractionWidth) products from the multiplier and hands the result off on valid/ready.
module accum #(
  parameter int wholeWidth    = 16,
  parameter int fractionWidth = 16,
  parameter int countWidth    = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [countWidth-1:0]               length,
  input  logic                                product_valid,
  input  logic [wholeWidth+fractionWidth-1:0] product,
  output logic                                product_ready,
  output logic [wholeWidth+fractionWidth-1:0] sum,
  output logic                                sum_valid,
  input  logic                                sum_ready,
  output logic                                overflow,
  output logic                                busy
);

  localparam int dataWidth = wholeWidth + fractionWidth;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } stateType;

  stateType              state;
  stateType              nextState;
  logic [dataWidth-1:0]  accReg;
  logic                  overflowReg;
  logic [countWidth-1:0] remaining;
  logic [dataWidth:0]    wideSum;
  logic                  beat;

  assign beat    = product_valid && product_ready;
  assign wideSum = {1'b0, accReg} + {1'b0, product};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    nextState     = state;
    product_ready = 1'b0;
    sum_valid     = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = (length != '0) ? ACCUM : DONE;
      end
      ACCUM: begin
        product_ready = 1'b1;
        busy          = 1'b1;
        if (beat && remaining == countWidth'(1)) nextState = DONE;
      end
      DONE: begin
        sum_valid = 1'b1;
        busy      = 1'b1;
        if (sum_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      accReg      <= '0;
      overflowReg <= 1'b0;
      remaining   <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start) begin
            remaining   <= length;
            accReg      <= '0;
            overflowReg <= 1'b0;
          end
        end
        ACCUM: begin
          if (beat) begin
            // A carry out means the true sum no longer fits; pin to full scale.
            if (wideSum[dataWidth]) begin
              accReg      <= '1;
              overflowReg <= 1'b1;
            end else begin
              accReg <= wideSum[dataWidth-1:0];
            end
            remaining <= remaining - countWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = accReg;
  assign overflow = overflowReg;

endmodule

// File: tb/tb_accum.sv
// Directed self-checking bench for accum: basic run, saturation, backpressure,
// zero length, mid-run reset and start pulses outside IDLE.
module tb_accum;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  length;
  logic        product_valid;
  logic [31:0] product;
  logic        product_ready;
  logic [31:0] sum;
  logic        sum_valid;
  logic        sum_ready;
  logic        overflow;
  logic        busy;

  int passCount  = 0;
  int totalCount = 0;

  accum #(.wholeWidth(16), .fractionWidth(16), .countWidth(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .length        (length),
    .product_valid (product_valid),
    .product       (product),
    .product_ready (product_ready),
    .sum           (sum),
    .sum_valid     (sum_valid),
    .sum_ready     (sum_ready),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic checkIdle(input string tag);
    check({tag, " busy"},          32'(busy),          0);
    check({tag, " product_ready"}, 32'(product_ready), 0);
    check({tag, " sum_valid"},     32'(sum_valid),     0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; length = '0;
    product_valid = 1'b0; product = '0; sum_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    checkIdle("reset");
    check("reset sum",      sum,            32'h0);
    check("reset overflow", 32'(overflow),  0);

    // Basic run: 1.5 + 2.25 + 0.25 = 4.0
    sum_ready = 1'b1;
    start = 1'b1; length = 8'd3;
    tick();
    start = 1'b0;
    check("basic accum busy",  32'(busy),          1);
    check("basic accum ready", 32'(product_ready), 1);
    product_valid = 1'b1; product = 32'h0001_8000; tick();
    product = 32'h0002_4000; tick();
    product = 32'h0000_4000;
    check("basic no early valid", 32'(sum_valid), 0);
    tick();
    product_valid = 1'b0;
    check("basic sum_valid",     32'(sum_valid),     1);
    check("basic sum",           sum,                32'h0004_0000);
    check("basic overflow",      32'(overflow),      0);
    check("basic done not ready", 32'(product_ready), 0);
    tick();
    checkIdle("basic after handshake");
    check("basic sum held in idle", sum, 32'h0004_0000);

    // Saturation
    start = 1'b1; length = 8'd2; tick();
    start = 1'b0;
    product_valid = 1'b1; product = 32'hFFFF_0000; tick();
    product = 32'h0002_0000; tick();
    product_valid = 1'b0;
    check("sat sum_valid", 32'(sum_valid), 1);
    check("sat sum",       sum,            32'hFFFF_FFFF);
    check("sat overflow",  32'(overflow),  1);
    tick();
    check("sat overflow held in idle", 32'(overflow), 1);
    start = 1'b1; length = 8'd1; tick();
    start = 1'b0;
    check("sat followup sum cleared",      sum,           32'h0);
    check("sat followup overflow cleared", 32'(overflow), 0);
    product_valid = 1'b1; product = 32'h0001_0000; tick();
    product_valid = 1'b0;
    check("sat followup sum",      sum,           32'h0001_0000);
    check("sat followup overflow", 32'(overflow), 0);
    tick();

    // Backpressure: bubbles on input, consumer stalls on output
    sum_ready = 1'b0;
    start = 1'b1; length = 8'd2; tick();
    start = 1'b0;
    product_valid = 1'b1; product = 32'h0001_1111; tick();
    product_valid = 1'b0; product = 32'h0005_5555; tick();
    tick();
    check("bp bubble still busy", 32'(busy),      1);
    check("bp bubble no valid",   32'(sum_valid), 0);
    product_valid = 1'b1; product = 32'h0002_2222; tick();
    product_valid = 1'b0; product = 32'h0000_DEAD;
    for (int i = 0; i < 5; i++) begin
      check("bp held sum_valid", 32'(sum_valid), 1);
      check("bp held sum",       sum,            32'h0003_3333);
      if (i < 4) tick();
    end
    sum_ready = 1'b1; tick();
    checkIdle("bp released");

    // Zero length goes straight to DONE
    start = 1'b1; length = 8'd0;
    product_valid = 1'b1; product = 32'h0000_0005;
    tick();
    start = 1'b0; sum_ready = 1'b0;
    check("zero sum_valid",     32'(sum_valid),     1);
    check("zero sum",           sum,                32'h0);
    check("zero overflow",      32'(overflow),      0);
    check("zero product_ready", 32'(product_ready), 0);
    tick();
    check("zero product_ready held", 32'(product_ready), 0);
    check("zero sum held",           sum,                32'h0);
    product_valid = 1'b0; sum_ready = 1'b1; tick();
    checkIdle("zero released");

    // Reset in the middle of a run
    start = 1'b1; length = 8'd4; tick();
    start = 1'b0;
    product_valid = 1'b1; product = 32'h0001_0000; tick(); tick();
    product_valid = 1'b0;
    check("midreset partial sum", sum, 32'h0002_0000);
    reset = 1'b1; tick();
    reset = 1'b0;
    checkIdle("midreset");
    check("midreset sum", sum, 32'h0);
    start = 1'b1; length = 8'd1; tick();
    start = 1'b0;
    product_valid = 1'b1; product = 32'h0003_0000; tick();
    product_valid = 1'b0;
    check("midreset followup valid", 32'(sum_valid), 1);
    check("midreset followup sum",   sum,            32'h0003_0000);
    tick();

    // start held high through ACCUM and the DONE handshake
    sum_ready = 1'b0;
    start = 1'b1; length = 8'd2; tick();
    length = 8'd5;
    product_valid = 1'b1; product = 32'h0000_0100; tick();
    product = 32'h0000_0200; tick();
    product_valid = 1'b0;
    check("start-ignored count kept", 32'(sum_valid), 1);
    check("start-ignored sum",        sum,            32'h0000_0300);
    sum_ready = 1'b1; tick();
    checkIdle("start-ignored handshake");
    start = 1'b0; sum_ready = 1'b0; tick();
    checkIdle("start-ignored stays idle");

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
